lfsr_seq_ctrl: RTL and testbench

//  Sequencer for the serial LFSR generator datapath: captures a seed and run lengths
//  on a start pulse, loads the seed, runs a warm-up phase, then a serial-out phase.

---
 rtl/lfsr_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// Control sequencer for the serial LFSR generator: captures seed and phase lengths on start,
// then walks LOAD -> WARM -> SHIFT -> DONE, issuing registered strobes to the datapath.
module lfsr_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] warm_len,
    input  logic [CNT_W-1:0] frame_len,
    output logic             seed_ld,
    output logic [WIDTH-1:0] seed_out,
    output logic             lfsr_en,
    output logic             shift_en,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WARM  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic               abort_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        warm_d    = warm_q;
        frame_d   = frame_q;
        seed_d    = seed_q;
        abort_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    seed_d  = seed_in;
                    warm_d  = warm_len;
                    frame_d = frame_len;
                end
            end
            LOAD: begin
                cnt_d = '0;
                if (abort) begin
                    state_d   = IDLE;
                    abort_hit = 1'b1;
                end else if (warm_q != '0) begin
                    state_d = WARM;
                end else if (frame_q != '0) begin
                    state_d = SHIFT;
                end else begin
                    state_d = DONE;
                end
            end
            WARM: begin
                if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    abort_hit = 1'b1;
                end else if (cnt_q == warm_q - CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = (frame_q != '0) ? SHIFT : DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    abort_hit = 1'b1;
                end else if (cnt_q == frame_q - CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                // abort here is deliberately silent: the run already completed
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are registered from the next-state decode so each is high exactly in its state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            warm_q   <= '0;
            frame_q  <= '0;
            seed_q   <= '0;
            seed_ld  <= 1'b0;
            lfsr_en  <= 1'b0;
            shift_en <= 1'b0;
            bit_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            warm_q   <= warm_d;
            frame_q  <= frame_d;
            seed_q   <= seed_d;
            seed_ld  <= (state_d == LOAD);
            lfsr_en  <= (state_d == WARM) || (state_d == SHIFT);
            shift_en <= (state_d == SHIFT);
            bit_idx  <= (state_d == SHIFT) ? cnt_d : '0;
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            aborted  <= abort_hit;
        end
    end

    assign seed_out = seed_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a per-run schedule of expected cycles (built from the phase lengths)
// is compared with the DUT outputs every clock, plus directed scenario checks.
module tb_lfsr_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] seed_in = '0;
    logic [3:0] warm_len = '0;
    logic [3:0] frame_len = '0;
    logic       seed_ld;
    logic [3:0] seed_out;
    logic       lfsr_en;
    logic       shift_en;
    logic [3:0] bit_idx;
    logic       busy;
    logic       done;
    logic       aborted;

    lfsr_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .seed_in(seed_in), .warm_len(warm_len), .frame_len(frame_len),
        .seed_ld(seed_ld), .seed_out(seed_out), .lfsr_en(lfsr_en),
        .shift_en(shift_en), .bit_idx(bit_idx), .busy(busy),
        .done(done), .aborted(aborted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ld;
        logic       en;
        logic       sh;
        logic [3:0] idx;
        logic       bz;
        logic       dn;
        logic       ab;
    } cyc_t;

    cyc_t       plan[$];
    cyc_t       exp_c = '0;
    logic [3:0] exp_seed = '0;

    int total = 0;
    int bad = 0;
    int n_done, n_warm, n_sh, n_busy, n_ab;
    logic [3:0] last_idx;

    function automatic logic [13:0] obs_vec();
        return {seed_ld, lfsr_en, shift_en, bit_idx, busy, done, aborted, seed_out};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {exp_c, exp_seed};
    endfunction

    function automatic cyc_t mk(logic ld, logic en, logic sh, logic [3:0] idx, logic dn);
        cyc_t c;
        c.ld = ld; c.en = en; c.sh = sh; c.idx = idx; c.bz = 1'b1; c.dn = dn; c.ab = 1'b0;
        return c;
    endfunction

    task automatic clear_stats();
        n_done = 0; n_warm = 0; n_sh = 0; n_busy = 0; n_ab = 0; last_idx = '0;
    endtask

    // One clock: drive inputs, advance the schedule model at the edge, sample 1 time unit later.
    task automatic step(input logic s, input logic a);
        start = s;
        abort = a;
        @(posedge CLK);
        if (exp_c.bz) begin
            if (a && !exp_c.dn) begin
                plan.delete();
                exp_c = '0;
                exp_c.ab = 1'b1;
            end else if (plan.size() > 0) begin
                exp_c = plan.pop_front();
            end else begin
                exp_c = '0;
            end
        end else if (s && !a) begin
            exp_seed = seed_in;
            plan.delete();
            plan.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
            for (int i = 0; i < int'(warm_len); i++) plan.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
            for (int i = 0; i < int'(frame_len); i++) plan.push_back(mk(1'b0, 1'b1, 1'b1, 4'(i), 1'b0));
            plan.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 1'b1));
            exp_c = plan.pop_front();
        end else begin
            exp_c = '0;
        end
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (done) n_done++;
        if (aborted) n_ab++;
        if (busy) n_busy++;
        if (lfsr_en && !shift_en) n_warm++;
        if (shift_en) begin
            n_sh++;
            last_idx = bit_idx;
        end
    endtask

    task automatic model_reset();
        plan.delete();
        exp_c = '0;
        exp_seed = '0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (obs_vec() !== 14'd0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs_vec(), 14'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_idle c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        seed_in = 4'b1010; warm_len = 4'd2; frame_len = 4'd6;
        step(1'b1, 1'b0);
        for (int i = 0; i < 10 && !shift_en; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (!(shift_en && busy)) begin
            bad++; $display("FAIL reset_reach_shift got sh=%b busy=%b want 1 1", shift_en, busy);
        end
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_async got=%h want=%h", obs_vec(), exp_vec());
        end
        @(negedge CLK);
        RST = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_after c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (n_done + n_ab !== 0) begin
            bad++; $display("FAIL reset_no_pulse got=%0d want=0", n_done + n_ab);
        end
    endtask

    task automatic test_nominal();
        int lat = 0;
        clear_stats();
        seed_in = 4'b1001; warm_len = 4'd8; frame_len = 4'd4;
        for (int i = 0; i < 30 && lat == 0; i++) begin
            step(i == 0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL nominal c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                total++;
                if (!(seed_ld && seed_out == 4'b1001)) begin
                    bad++; $display("FAIL nominal_load got ld=%b seed=%b want 1 1001", seed_ld, seed_out);
                end
            end
            if (done) lat = i + 1;
        end
        total++;
        if (lat != 14 || n_busy != 14 || n_warm != 8 || n_sh != 4 || last_idx != 4'd3) begin
            bad++; $display("FAIL nominal_counts got lat=%0d busy=%0d warm=%0d sh=%0d idx=%0d want 14 14 8 4 3",
                            lat, n_busy, n_warm, n_sh, last_idx);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        for (int k = 0; k < 2; k++) begin
            int lat = 0;
            int fr = (k == 0) ? 3 : 0;
            clear_stats();
            seed_in = 4'($urandom); warm_len = 4'd0; frame_len = 4'(fr);
            for (int i = 0; i < 20 && lat == 0; i++) begin
                step(i == 0, 1'b0);
                total++;
                if (obs_vec() !== exp_vec()) begin
                    bad++; $display("FAIL zero_len k%0d c%0d got=%h want=%h", k, i, obs_vec(), exp_vec());
                end
                if (done) lat = i + 1;
            end
            total++;
            if (lat != 2 + fr || n_warm != 0 || n_sh != fr) begin
                bad++; $display("FAIL zero_len_counts k%0d got lat=%0d warm=%0d sh=%0d want %0d 0 %0d",
                                k, lat, n_warm, n_sh, 2 + fr, fr);
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        seed_in = 4'b0011; warm_len = 4'd5; frame_len = 4'd2;
        step(1'b1, 1'b0);
        for (int i = 0; i < 30 && !done; i++) begin
            if (i == 2) seed_in = 4'b0110;
            step(i == 2, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL busy_start c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (n_done != 1 || seed_out != 4'b0011) begin
            bad++; $display("FAIL busy_start_result got done=%0d seed=%b want 1 0011", n_done, seed_out);
        end
        step(1'b1, 1'b0);
        total++;
        if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_in_done got=%h want=%h", obs_vec(), exp_vec());
        end
        step(1'b1, 1'b0);
        total++;
        if (!(seed_ld && seed_out == 4'b0110) || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_after_done got=%h want=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 30 && busy; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_abort();
        clear_stats();
        seed_in = 4'b1100; warm_len = 4'd3; frame_len = 4'd4;
        step(1'b1, 1'b0);
        for (int i = 0; i < 20 && !(shift_en && bit_idx == 4'd1); i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        total++;
        if (!(aborted && !busy && !shift_en && !done) || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL abort_shift got=%h want=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        total++;
        if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL abort_with_start got=%h want=%h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        total++;
        if (n_done != 0 || n_ab != 1 || n_busy != 0 + 1 + 3 + 2) begin
            bad++; $display("FAIL abort_counts got done=%0d ab=%0d busy=%0d want 0 1 6", n_done, n_ab, n_busy);
        end
    endtask

    task automatic test_max_len();
        int lat = 0;
        clear_stats();
        seed_in = 4'b1111; warm_len = 4'd15; frame_len = 4'd15;
        for (int i = 0; i < 50 && lat == 0; i++) begin
            step(i == 0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL max_len c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            if (done) lat = i + 1;
        end
        total++;
        if (lat != 32 || n_warm != 15 || n_sh != 15 || last_idx != 4'd14) begin
            bad++; $display("FAIL max_len_counts got lat=%0d warm=%0d sh=%0d idx=%0d want 32 15 15 14",
                            lat, n_warm, n_sh, last_idx);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        int errs = 0;
        clear_stats();
        for (int i = 0; i < 1500; i++) begin
            seed_in   = 4'($urandom);
            warm_len  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            frame_len = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
            step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL random c%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (n_done == 0) begin
            bad++; $display("FAIL random_activity got done=%0d want >0", n_done);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_back_to_back();
        test_abort();
        test_max_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
